// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared encodings and lane helpers for the data-memory controller
// Rev 1.0
// ============================================================================
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_BUSY = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_REQ  = 3'd4;
  localparam logic [2:0] ST_WR_BUSY = 3'd5;
  localparam logic [2:0] ST_WR_WAIT = 3'd6;
  localparam logic [2:0] ST_RESP    = 3'd7;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane.sv
`default_nettype none
// ============================================================================
// dmem_lane : byte/half lane extraction for loads and lane merge for RMW stores
// Rev 1.0
// ============================================================================
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  assign o_load  = load_extract(i_word, i_off, i_size, i_unsigned);
  assign o_merge = store_merge(i_word, i_off, i_size, i_wdata);

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : initiator-side controller between the MEM stage and the
//             multi-cycle data memory (pulse protocol, RMW sub-word stores)
// Rev 1.0
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_read,
  output logic        o_mem_write,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready
);

  logic [2:0]      r_state;
  req_t            r_req;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic            r_resp_err;
  logic [31:0]     r_resp_rdata;

  logic            w_bad;
  logic            w_to_hit;
  logic [31:0]     w_load;
  logic [31:0]     w_merge;

  assign w_bad    = is_misaligned(i_req_size, i_req_addr[1:0]);
  // Abort on the edge that closes the TIMEOUT-th cycle spent in a wait state
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Lane logic looks straight at the returning word so the load result and
  // the RMW merge are both ready on the completion edge
  dmem_lane u_lane (
    .i_word     (i_mem_rdata),
    .i_off      (r_req.off),
    .i_size     (r_req.size),
    .i_unsigned (r_req.uns),
    .i_wdata    (r_req.wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_req        <= '0;
      r_to_cnt     <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      // Strobes are one-cycle pulses unless a branch below raises them
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_req        <= '{we: i_req_we, size: i_req_size, uns: i_req_unsigned,
                              off: i_req_addr[1:0], wdata: i_req_wdata};
            r_mem_addr   <= {i_req_addr[31:2], 2'b00};
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            if (w_bad) begin
              r_resp_err <= 1'b1;
              r_state    <= ST_RESP;
            end else if (i_req_we && (i_req_size == SZ_W)) begin
              r_mem_wdata <= i_req_wdata;
              r_mem_write <= 1'b1;
              r_state     <= ST_WR_REQ;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= ST_RD_REQ;
            end
          end
        end

        ST_RD_REQ: begin
          r_to_cnt <= '0;
          r_state  <= ST_RD_BUSY;
        end

        ST_RD_BUSY: begin
          if (!i_mem_ready) begin
            r_to_cnt <= '0;
            r_state  <= ST_RD_WAIT;
          end else if (w_to_hit) begin
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_RD_WAIT: begin
          if (i_mem_ready) begin
            if (r_req.we) begin
              r_mem_wdata <= w_merge;
              r_mem_write <= 1'b1;
              r_state     <= ST_WR_REQ;
            end else begin
              r_resp_rdata <= w_load;
              r_state      <= ST_RESP;
            end
          end else if (w_to_hit) begin
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_WR_REQ: begin
          r_to_cnt <= '0;
          r_state  <= ST_WR_BUSY;
        end

        ST_WR_BUSY: begin
          if (!i_mem_ready) begin
            r_to_cnt <= '0;
            r_state  <= ST_WR_WAIT;
          end else if (w_to_hit) begin
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_WR_WAIT: begin
          if (i_mem_ready) begin
            r_state <= ST_RESP;
          end else if (w_to_hit) begin
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_resp_valid = (r_state == ST_RESP);
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_read   = r_mem_read;
  assign o_mem_write  = r_mem_write;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_ctrl : table vectors, corner sequences and randomized traffic against
//                a word-array reference model with a 3-cycle memory model
// ============================================================================
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int LAT     = 3;

  logic        clk, rst;
  logic        i_req_valid, i_req_we, i_req_unsigned;
  logic [1:0]  i_req_size;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_read, o_mem_write;
  logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  dmem_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_req_ready    (o_req_ready),
    .o_resp_valid   (o_resp_valid),
    .o_resp_rdata   (o_resp_rdata),
    .o_resp_err     (o_resp_err),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
    .i_mem_rdata    (mem_rdata),
    .i_mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i == 12) return 32'h11223344;
    return 32'h9E3779B9 * (i + 1);
  endfunction

  // Memory model: accepts a pulse while idle, stays busy LAT sampled cycles
  logic [31:0] mem [0:63];
  bit          mem_inited = 1'b0;
  bit          stuck = 1'b0;
  int          mcnt;
  logic        mop_we;
  logic [5:0]  midx;
  logic [31:0] mwd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b1;
      mem_rdata <= '0;
      mcnt      <= 0;
      if (!mem_inited) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        mem_inited <= 1'b1;
      end
    end else if (mem_ready) begin
      if (!stuck && (o_mem_read || o_mem_write)) begin
        mem_ready <= 1'b0;
        mcnt      <= LAT - 1;
        mop_we    <= o_mem_write;
        midx      <= o_mem_addr[7:2];
        mwd       <= o_mem_wdata;
      end
    end else if (mcnt == 0) begin
      mem_ready <= 1'b1;
      if (mop_we) mem[midx] <= mwd;
      else        mem_rdata <= mem[midx];
    end else begin
      mcnt <= mcnt - 1;
    end
  end

  logic [31:0] ref_mem [0:63];

  // Reference: expected response, latency and pulses from the access rules
  function automatic void ref_req(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err, output int lat,
                                  output int nrd, output int nwr, output logic [31:0] wword);
    int nb, sh, idx;
    logic [63:0] m;
    logic [31:0] word, val, mk;
    rdata = '0; err = 1'b0; lat = 1; nrd = 0; nwr = 0; wword = '0;
    idx = int'(addr[7:2]);
    sh  = 8 * int'(addr[1:0]);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3 || (int'(addr[1:0]) % nb) != 0) begin
      err = 1'b1;
      return;
    end
    m    = (64'd1 << (8 * nb)) - 64'd1;
    mk   = m[31:0];
    word = ref_mem[idx];
    if (!we) begin
      val = (word >> sh) & mk;
      if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mk;
      rdata = val; lat = 6; nrd = 1;
    end else if (nb == 4) begin
      ref_mem[idx] = wdata; wword = wdata; lat = 6; nwr = 1;
    end else begin
      wword = (word & ~(mk << sh)) | ((wdata & mk) << sh);
      ref_mem[idx] = wword; lat = 11; nrd = 1; nwr = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge and follow it to its response pulse
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] wword,
                         output logic [31:0] paddr, output bit held);
    int w;
    bit prd, pwr;
    rdata = '0; err = 1'b0; lat = -1; nrd = 0; nwr = 0; wword = '0; paddr = '0;
    held = 1'b0; prd = 1'b0; pwr = 1'b0;
    w = 0;
    while (!o_req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_wdata = $urandom;
        i_req_size  = 2'($urandom);
      end
      if (o_mem_read)  begin nrd++; paddr = o_mem_addr; held |= prd; end
      if (o_mem_write) begin nwr++; paddr = o_mem_addr; wword = o_mem_wdata; held |= pwr; end
      prd = o_mem_read;
      pwr = o_mem_write;
      if (o_resp_valid) begin
        rdata = o_resp_rdata;
        err   = o_resp_err;
        lat   = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t vt [16];

  initial begin
    automatic logic [31:0] rd, ww, pa, e_rd, e_ww;
    automatic logic er, e_er, we, uns;
    automatic logic [1:0] sz;
    automatic logic [31:0] ad, wd;
    automatic int lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    automatic bit held;

    vt[0]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 6,  1, 0, 32'h0};
    vt[1]  = '{1'b0, SZ_B, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 6,  1, 0, 32'h0};
    vt[2]  = '{1'b0, SZ_B, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0, 6,  1, 0, 32'h0};
    vt[3]  = '{1'b0, SZ_H, 1'b0, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 6,  1, 0, 32'h0};
    vt[4]  = '{1'b1, SZ_B, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0,        1'b0, 11, 1, 1, 32'hDEAD55EF};
    vt[5]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 6,  1, 0, 32'h0};
    vt[6]  = '{1'b1, SZ_W, 1'b0, 32'h02, 32'h12345678, 32'h0,        1'b1, 1,  0, 0, 32'h0};
    vt[7]  = '{1'b0, SZ_H, 1'b0, 32'h01, 32'h0,        32'h0,        1'b1, 1,  0, 0, 32'h0};
    vt[8]  = '{1'b0, SZ_W, 1'b0, 32'h10, 32'h0,        32'hDEAD55EF, 1'b0, 6,  1, 0, 32'h0};
    vt[9]  = '{1'b0, SZ_X, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1,  0, 0, 32'h0};
    vt[10] = '{1'b1, SZ_H, 1'b0, 32'h12, 32'h1234ABCD, 32'h0,        1'b0, 11, 1, 1, 32'hABCD55EF};
    vt[11] = '{1'b0, SZ_H, 1'b1, 32'h12, 32'h0,        32'h0000ABCD, 1'b0, 6,  1, 0, 32'h0};
    vt[12] = '{1'b1, SZ_W, 1'b0, 32'h20, 32'h80000001, 32'h0,        1'b0, 6,  0, 1, 32'h80000001};
    vt[13] = '{1'b0, SZ_B, 1'b0, 32'h20, 32'h0,        32'h00000001, 1'b0, 6,  1, 0, 32'h0};
    vt[14] = '{1'b0, SZ_H, 1'b0, 32'h22, 32'h0,        32'hFFFF8000, 1'b0, 6,  1, 0, 32'h0};
    vt[15] = '{1'b0, SZ_B, 1'b1, 32'h23, 32'h0,        32'h00000080, 1'b0, 6,  1, 0, 32'h0};

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'b00;
    i_req_unsigned = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  32'(o_req_ready),  32'd1);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("rst_resp_err",   32'(o_resp_err),   32'd0);
    chk("rst_resp_rdata", o_resp_rdata,      32'd0);
    chk("rst_mem_rw",     {30'd0, o_mem_read, o_mem_write}, 32'd0);
    chk("rst_mem_addr",   o_mem_addr,  32'd0);
    chk("rst_mem_wdata",  o_mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      ref_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
              e_rd, e_er, e_lat, e_nrd, e_nwr, e_ww);
      run_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
              rd, er, lat, nrd, nwr, ww, pa, held);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_reads", i), nrd, vt[i].exp_nrd);
      chk($sformatf("vec%0d_writes", i), nwr, vt[i].exp_nwr);
      chk($sformatf("vec%0d_pulse_held", i), 32'(held), 32'd0);
      if (vt[i].exp_nwr > 0) chk($sformatf("vec%0d_mem_wdata", i), ww, vt[i].exp_wword);
      if (vt[i].exp_nrd + vt[i].exp_nwr > 0)
        chk($sformatf("vec%0d_mem_addr", i), pa, {vt[i].addr[31:2], 2'b00});
    end

    // Memory that never goes busy: the read must time out
    stuck = 1'b1;
    run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, ww, pa, held);
    chk("timeout_err",   32'(er), 32'd1);
    chk("timeout_rdata", rd, 32'd0);
    chk("timeout_reads", nrd, 32'd1);
    chk("timeout_latency_window", 32'(lat >= TIMEOUT + 1 && lat <= TIMEOUT + 3), 32'd1);
    @(negedge clk);
    chk("timeout_req_ready", 32'(o_req_ready), 32'd1);
    stuck = 1'b0;

    // Asynchronous reset while a word store sits in WR_WAIT
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = SZ_W; i_req_unsigned = 1'b0;
    i_req_addr = 32'h30; i_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready",  32'(o_req_ready),  32'd1);
    chk("arst_resp_valid", 32'(o_resp_valid), 32'd0);
    chk("arst_mem_rw",     {30'd0, o_mem_read, o_mem_write}, 32'd0);
    chk("arst_mem_addr",   o_mem_addr,  32'd0);
    chk("arst_mem_wdata",  o_mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(1'b0, SZ_W, 1'b0, 32'h30, 32'h0, rd, er, lat, nrd, nwr, ww, pa, held);
    chk("post_rst_rdata",   rd, 32'h11223344);
    chk("post_rst_err",     32'(er), 32'd0);
    chk("post_rst_latency", lat, 32'd6);

    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ad  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_W) ad[1:0] = 2'b00;
        if (sz == SZ_H) ad[0]   = 1'b0;
      end
      wd = $urandom;
      ref_req(we, sz, uns, ad, wd, e_rd, e_er, e_lat, e_nrd, e_nwr, e_ww);
      run_req(we, sz, uns, ad, wd, rd, er, lat, nrd, nwr, ww, pa, held);
      chk($sformatf("rnd%0d_rdata", n), rd, e_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_latency", n), lat, e_lat);
      chk($sformatf("rnd%0d_pulses", n), nrd * 4 + nwr, e_nrd * 4 + e_nwr);
      chk($sformatf("rnd%0d_pulse_held", n), 32'(held), 32'd0);
      if (e_nwr > 0) chk($sformatf("rnd%0d_mem_wdata", n), ww, e_ww);
      if (e_nrd + e_nwr > 0) chk($sformatf("rnd%0d_mem_addr", n), pa, {ad[31:2], 2'b00});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Initiator-side controller for the multi-cycle data memory. It sits between the CPU MEM stage and the data memory.
- Accepts byte, half and word load/store requests and drives the single-cycle mem_read/mem_write pulse protocol. It holds the address and data stable until mem_ready returns.
- Stores smaller than a word are done as read-modify-write, because the memory only writes whole words. Loads smaller than a word are extracted and sign- or zero-extended.
- Provides the pipeline stall (req_ready) and a one-cycle response pulse.

Parameters:
- TIMEOUT, 15: maximum cycles spent in any memory-wait state before the access is aborted with resp_err=1.
- TO_W, 4: width of the timeout counter; it must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request strobe from the MEM stage; sampled only when req_ready=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_ready  out  1  controller idle; stall = ~req_ready
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), held for the whole access
- mem_wdata  out  32  full word to write, held for the whole access
- mem_read  out  1  registered, one-cycle pulse
- mem_write  out  1  registered, one-cycle pulse
- mem_rdata  in  32  read word from memory
- mem_ready  in  1  memory idle/complete; high while the memory is idle

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, timeout counter=0.
- States: IDLE, RD_REQ, RD_BUSY, RD_WAIT, WR_REQ, WR_BUSY, WR_WAIT, RESP.
- Acceptance (IDLE with req_valid=1): latch the request, set req_ready=0.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with err=1; no memory access.
  - Load, or store of a byte/half -> RD_REQ.
  - Store of a word -> WR_REQ with mem_wdata=req_wdata.
- RD_REQ / WR_REQ:
  - mem_read (or mem_write)=1 for exactly this one cycle.
  - Next state RD_BUSY / WR_BUSY.
  - The pulse must never be held: if it were still high when the memory returns to idle, the memory would restart the access.
- *_BUSY: wait for mem_ready=0, then go to *_WAIT.
- *_WAIT: wait for mem_ready=1. This completes the access, because mem_ready is only trusted after it has been seen low.
- RD_WAIT completion, at the edge mem_ready=1 is sampled, the controller captures mem_rdata:
  - Load: lane select by addr[1:0] (byte) or addr[1] (half), extend, -> RESP.
  - Store: merge req_wdata into the captured word at the selected byte/half lane, put the result on mem_wdata, -> WR_REQ.
- WR_WAIT completion -> RESP.
- RESP: resp_valid=1 for one cycle, then IDLE with req_ready=1. A new request can be accepted on the following edge.
- Timeout: counter clears on entry to each BUSY/WAIT state and increments every cycle spent there.
  - On reaching TIMEOUT: mem_read/mem_write stay 0, go to RESP with err=1 and resp_rdata=0.
- mem_addr and mem_wdata change only in IDLE (on acceptance) and at the RD_WAIT->WR_REQ transition.
- Sign extension: LB uses bit[7] of the byte, LH bit[15]; LW ignores req_unsigned.
- Reset mid-operation: return to IDLE immediately. The memory shares rst, so there is no outstanding access to drain. Any write in flight is lost.
- req_valid while busy is ignored; the stage is stalled upstream.
- Nominal latency with a 3-cycle memory, acceptance edge to resp_valid high:
  - word load or store: 6 cycles.
  - byte/half store: 11 cycles.
  - misaligned: 1 cycle.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B, SZ_H, SZ_W.
  - state encodings.
  - function for load extraction/extension.
  - function for store lane merge.
- Sub-module dmem_lane (combinational): inputs word, addr[1:0], size, unsigned, store data. Outputs extended load value and merged store word. Shared by the load and RMW paths.

Test Plan:
- Reset, then LW at 0x10 after memory preload 0xDEADBEEF -> one mem_read pulse, mem_addr=0x10; resp_rdata=0xDEADBEEF, err=0, 6 cycles after acceptance.
- LB at 0x13 and LBU at 0x13, same word -> 0xFFFFFFDE and 0x000000DE; LH at 0x12 -> 0xFFFFDEAD.
- SB 0x55 at 0x11 with word 0xDEADBEEF -> one mem_read, then one mem_write with mem_wdata=0xDEAD55EF; following LW returns 0xDEAD55EF; resp 11 cycles after acceptance.
- SW at 0x02 and LH at 0x01 -> resp_err=1 one cycle after acceptance; no mem_read/mem_write pulse; memory unchanged.
- Memory model holding mem_ready=1 forever (never goes busy) -> resp_err=1 after TIMEOUT cycles in RD_BUSY; req_ready returns to 1.
- Assert rst during WR_WAIT of an SW -> all outputs reach reset values asynchronously; an LW issued after reset completes normally.
